// File: rtl/timekeeper.sv
// Real-time clock: one-second prescaler, BCD hour/minute/second in 24h or 12h+PM mode,
// validated time loads and a single armed alarm.
module timekeeper #(
  parameter int unsigned CLK_HZ   = 50000000,
  parameter bit          H24      = 1'b1,
  parameter bit          ALARM_EN = 1'b1
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       run,
  input  logic       set_load,
  input  logic [7:0] set_hour,
  input  logic [7:0] set_minute,
  input  logic [7:0] set_second,
  input  logic       set_pm,
  input  logic       alarm_load,
  input  logic       alarm_clear,
  output logic [7:0] hour,
  output logic [7:0] minute,
  output logic [7:0] second,
  output logic       pm,
  output logic       tick,
  output logic       alarm_hit,
  output logic       set_err,
  output logic       alarm_armed
);

  localparam int unsigned   PW       = (CLK_HZ > 2) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PresMax  = PW'(CLK_HZ - 1);
  localparam logic [7:0]    HourRst  = H24 ? 8'h00 : 8'h12;

  logic [PW-1:0] presc_q, presc_d;
  logic [7:0]    hour_q, hour_d, min_q, min_d, sec_q, sec_d;
  logic          pm_q, pm_d;
  logic          tick_q, tick_d, hit_q, hit_d, err_q, err_d;
  logic          armed_q, armed_d;
  logic [7:0]    al_hour_q, al_hour_d, al_min_q, al_min_d, al_sec_q, al_sec_d;
  logic          al_pm_q, al_pm_d;

  logic          advance, set_valid, load_ok, load_bad, alm_ok, alm_bad;
  logic [7:0]    adv_hour, adv_min, adv_sec;
  logic          adv_pm, sec_wrap, min_wrap;

  function automatic logic bcd_ok(input logic [7:0] v);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
  endfunction

  function automatic logic time_ok(input logic [7:0] h, input logic [7:0] m,
                                   input logic [7:0] s);
    logic hour_range;
    hour_range = H24 ? (h <= 8'h23) : ((h != 8'h00) && (h <= 8'h12));
    return bcd_ok(h) && bcd_ok(m) && bcd_ok(s) && (m <= 8'h59) && (s <= 8'h59) && hour_range;
  endfunction

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    else                return {v[7:4], v[3:0] + 4'd1};
  endfunction

  assign advance   = run && (presc_q == PresMax);
  assign set_valid = time_ok(set_hour, set_minute, set_second);
  assign load_ok   = set_load && set_valid;
  assign load_bad  = set_load && !set_valid;
  assign alm_ok    = ALARM_EN && alarm_load && set_valid;
  assign alm_bad   = ALARM_EN && alarm_load && !set_valid;

  // Time after one second elapses, with BCD carries.
  always_comb begin
    sec_wrap = (sec_q == 8'h59);
    min_wrap = (min_q == 8'h59);
    adv_sec  = sec_wrap ? 8'h00 : bcd_inc(sec_q);
    adv_min  = min_q;
    adv_hour = hour_q;
    adv_pm   = pm_q;
    if (sec_wrap) begin
      adv_min = min_wrap ? 8'h00 : bcd_inc(min_q);
      if (min_wrap) begin
        if (H24) begin
          adv_hour = (hour_q == 8'h23) ? 8'h00 : bcd_inc(hour_q);
        end else begin
          adv_hour = (hour_q == 8'h12) ? 8'h01 : bcd_inc(hour_q);
          // PM flips on the 11 -> 12 transition, not on 12 -> 01.
          if (hour_q == 8'h11) adv_pm = ~pm_q;
        end
      end
    end
  end

  always_comb begin
    presc_d   = presc_q;
    hour_d    = hour_q;
    min_d     = min_q;
    sec_d     = sec_q;
    pm_d      = pm_q;
    tick_d    = 1'b0;
    hit_d     = 1'b0;
    err_d     = load_bad || alm_bad;
    armed_d   = armed_q;
    al_hour_d = al_hour_q;
    al_min_d  = al_min_q;
    al_sec_d  = al_sec_q;
    al_pm_d   = al_pm_q;

    if (run) presc_d = advance ? '0 : presc_q + PW'(1);

    // A valid load overrides a coincident advance and restarts the second.
    if (load_ok) begin
      hour_d  = set_hour;
      min_d   = set_minute;
      sec_d   = set_second;
      pm_d    = H24 ? 1'b0 : set_pm;
      presc_d = '0;
    end else if (advance) begin
      hour_d = adv_hour;
      min_d  = adv_min;
      sec_d  = adv_sec;
      pm_d   = adv_pm;
      tick_d = 1'b1;
      hit_d  = ALARM_EN && armed_q && (adv_hour == al_hour_q) && (adv_min == al_min_q) &&
               (adv_sec == al_sec_q) && (H24 || (adv_pm == al_pm_q));
    end

    if (alarm_clear) begin
      armed_d = 1'b0;
    end else if (alm_ok) begin
      armed_d   = 1'b1;
      al_hour_d = set_hour;
      al_min_d  = set_minute;
      al_sec_d  = set_second;
      al_pm_d   = H24 ? 1'b0 : set_pm;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      presc_q   <= '0;
      hour_q    <= HourRst;
      min_q     <= 8'h00;
      sec_q     <= 8'h00;
      pm_q      <= 1'b0;
      tick_q    <= 1'b0;
      hit_q     <= 1'b0;
      err_q     <= 1'b0;
      armed_q   <= 1'b0;
      al_hour_q <= HourRst;
      al_min_q  <= 8'h00;
      al_sec_q  <= 8'h00;
      al_pm_q   <= 1'b0;
    end else begin
      presc_q   <= presc_d;
      hour_q    <= hour_d;
      min_q     <= min_d;
      sec_q     <= sec_d;
      pm_q      <= pm_d;
      tick_q    <= tick_d;
      hit_q     <= hit_d;
      err_q     <= err_d;
      armed_q   <= armed_d;
      al_hour_q <= al_hour_d;
      al_min_q  <= al_min_d;
      al_sec_q  <= al_sec_d;
      al_pm_q   <= al_pm_d;
    end
  end

  assign hour        = hour_q;
  assign minute      = min_q;
  assign second      = sec_q;
  assign pm          = pm_q;
  assign tick        = tick_q;
  assign alarm_hit   = hit_q;
  assign set_err     = err_q;
  assign alarm_armed = armed_q;

endmodule
